// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared types and constants for the Pong match/score logic:
//                match state encoding, winner codes and the active-low
//                seven-segment digit table ({g,f,e,d,c,b,a}).
//  Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

  // Match state; two bits cover all four states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PLAY      = 2'd1,
    ST_PAUSE     = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_e;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  // All segments off (active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Any digit code outside 0-9 decodes to blank; used to suppress a zero tens.
  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  // Active-low patterns for digits 9 down to 0 (index = digit).
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  // Split a 0-15 score into {tens, ones} without a divider.
  function automatic logic [7:0] split_score(input logic [3:0] value);
    logic       tens;
    logic [3:0] ones;
    tens = (value >= 4'd10);
    ones = tens ? (value - 4'd10) : value;
    return {3'b000, tens, ones};
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational 4-bit digit to active-low seven-segment
//                decoder. Codes above 9 produce a blank display.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
  import pong_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Table lookup for legal digits, blank for everything else.
  always_comb begin
    seg_o = SEG_BLANK;
    if (digit_i <= 4'd9) begin
      seg_o = SEG_TABLE[digit_i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/pong_score_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : pong_score_fsm
//  Description : Pong match controller. Consumes single-cycle point pulses,
//                keeps both scores, runs the post-point pause, detects the
//                winner and drives four seven-segment displays.
//  Revision    : 1.0 - initial release
// ============================================================================
module pong_score_fsm
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int PAUSE_CYCLES = 25_000_000,
  parameter int CNT_W        = 25
) (
  input  logic       pixel_clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       point_p1,
  input  logic       point_p2,
  output logic       game_active,
  output logic       serve_dir,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3
);

  localparam logic [3:0]       WIN_VAL    = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] PAUSE_LOAD = CNT_W'(PAUSE_CYCLES - 1);

  state_e           state_q, state_d;
  logic             start_q;
  logic [3:0]       score_p1_q, score_p1_d;
  logic [3:0]       score_p2_q, score_p2_d;
  logic             serve_q, serve_d;
  logic [1:0]       winner_q, winner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q;
  logic             over_q;
  logic [6:0]       hex0_q, hex1_q, hex2_q, hex3_q;

  logic             w_start_rise;
  logic [3:0]       w_p1_inc;
  logic [3:0]       w_p2_inc;
  logic [7:0]       w_split_p1;
  logic [7:0]       w_split_p2;
  logic [3:0]       w_digit [4];
  logic [6:0]       w_seg   [4];

  assign w_start_rise = start_btn & ~start_q;
  assign w_p1_inc     = score_p1_q + 4'd1;
  assign w_p2_inc     = score_p2_q + 4'd1;

  // Next-state, score, serve and winner logic for the match.
  always_comb begin
    state_d    = state_q;
    score_p1_d = score_p1_q;
    score_p2_d = score_p2_q;
    serve_d    = serve_q;
    winner_d   = winner_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_start_rise) begin
          score_p1_d = 4'd0;
          score_p2_d = 4'd0;
          serve_d    = 1'b0;
          state_d    = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (point_p1 && point_p2) begin
          // Simultaneous exits: replay the point with no score change.
          state_d = ST_PAUSE;
          cnt_d   = PAUSE_LOAD;
        end else if (point_p1) begin
          score_p1_d = w_p1_inc;
          serve_d    = 1'b1;
          if (w_p1_inc == WIN_VAL) begin
            state_d  = ST_GAME_OVER;
            winner_d = WINNER_P1;
          end else begin
            state_d = ST_PAUSE;
            cnt_d   = PAUSE_LOAD;
          end
        end else if (point_p2) begin
          score_p2_d = w_p2_inc;
          serve_d    = 1'b0;
          if (w_p2_inc == WIN_VAL) begin
            state_d  = ST_GAME_OVER;
            winner_d = WINNER_P2;
          end else begin
            state_d = ST_PAUSE;
            cnt_d   = PAUSE_LOAD;
          end
        end
      end
      ST_PAUSE: begin
        if (w_start_rise) begin
          score_p1_d = 4'd0;
          score_p2_d = 4'd0;
          serve_d    = 1'b0;
          state_d    = ST_PLAY;
        end else if (cnt_q == '0) begin
          state_d = ST_PLAY;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAME_OVER: begin
        if (w_start_rise) begin
          score_p1_d = 4'd0;
          score_p2_d = 4'd0;
          serve_d    = 1'b0;
          winner_d   = WINNER_NONE;
          state_d    = ST_PLAY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Match state and registered status outputs.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      score_p1_q <= 4'd0;
      score_p2_q <= 4'd0;
      serve_q    <= 1'b0;
      winner_q   <= WINNER_NONE;
      cnt_q      <= '0;
      active_q   <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_btn;
      score_p1_q <= score_p1_d;
      score_p2_q <= score_p2_d;
      serve_q    <= serve_d;
      winner_q   <= winner_d;
      cnt_q      <= cnt_d;
      active_q   <= (state_d == ST_PLAY);
      over_q     <= (state_d == ST_GAME_OVER);
    end
  end

  // Digit split of the current scores; a zero tens digit is blanked.
  assign w_split_p1 = split_score(score_p1_q);
  assign w_split_p2 = split_score(score_p2_q);
  assign w_digit[0] = w_split_p2[3:0];
  assign w_digit[1] = w_split_p2[4] ? 4'd1 : DIGIT_BLANK;
  assign w_digit[2] = w_split_p1[3:0];
  assign w_digit[3] = w_split_p1[4] ? 4'd1 : DIGIT_BLANK;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_seg
      seg7_decode u_seg7_decode (
        .digit_i (w_digit[g]),
        .seg_o   (w_seg[g])
      );
    end
  endgenerate

  // Registered display segments, one cycle behind the scores.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      hex0_q <= SEG_TABLE[0];
      hex1_q <= SEG_BLANK;
      hex2_q <= SEG_TABLE[0];
      hex3_q <= SEG_BLANK;
    end else begin
      hex0_q <= w_seg[0];
      hex1_q <= w_seg[1];
      hex2_q <= w_seg[2];
      hex3_q <= w_seg[3];
    end
  end

  assign game_active = active_q;
  assign serve_dir   = serve_q;
  assign score_p1    = score_p1_q;
  assign score_p2    = score_p2_q;
  assign game_over   = over_q;
  assign winner      = winner_q;
  assign hex0        = hex0_q;
  assign hex1        = hex1_q;
  assign hex2        = hex2_q;
  assign hex3        = hex3_q;

endmodule
`default_nettype wire
